sync_fifo_thresh: RTL and testbench
===================================

Name: sync_fifo_thresh

Overview:
Single-clock, parametrised FIFO and the next generation of the team's FIFO family, for blocks that share one clock domain and need no gray-code synchronisers. It adds several features to the basic pointer/full/empty scheme:
- occupancy count
- programmable almost-full / almost-empty thresholds
- sticky overflow / underflow error flags
- a selectable first-word-fall-through (FWFT) read mode

It sits between producer and consumer datapaths inside one clock domain.

Parameters:
DSIZE, 8, data word width in bits
ASIZE, 4, address width; DEPTH = 2**ASIZE entries
AFULL_TH, 12, almost_full asserted when count >= AFULL_TH (legal 1..DEPTH)
AEMPTY_TH, 2, almost_empty asserted when count <= AEMPTY_TH (legal 0..DEPTH-1)
FWFT, 0, 0 = standard registered read, 1 = first-word-fall-through

Ports:
clk  input  1  clock for all logic
rst  input  1  synchronous reset, active-high
wdata  input  DSIZE  write data
win  input  1  write request
rout  input  1  read request (in FWFT mode: pop the head)
rdata  output  DSIZE  read data
rvalid  output  1  standard mode: rdata valid this cycle; FWFT mode: equals !rempty
wfull  output  1  FIFO holds DEPTH entries
rempty  output  1  FIFO holds 0 entries
almost_full  output  1  count >= AFULL_TH
almost_empty  output  1  count <= AEMPTY_TH
count  output  ASIZE+1  current occupancy, 0..DEPTH
overflow  output  1  sticky: a write was attempted while wfull
underflow  output  1  sticky: a read was attempted while rempty
flag_clr  input  1  clears overflow/underflow on the next edge

Behaviour:
- Reset: the interface is one clock, clk, with a synchronous active-high reset, rst.
- rst sampled high at a clk edge forces the following, overriding all other inputs including flag_clr:
  - wptr = rptr = 0, count = 0
  - rempty = 1, wfull = 0
  - almost_empty = 1, almost_full = 0
  - rdata = 0, rvalid = 0
  - overflow = underflow = 0
- Memory contents are not reset. Reset mid-operation discards all stored data; the next write lands at address 0.
- Pointers: wptr and rptr are ASIZE+1 bits and wrap naturally modulo 2*DEPTH; the address is ptr[ASIZE-1:0].
- Accepted write: wen = win & !wfull. Data is stored at waddr on the edge and wptr increments.
- Accepted read: ren = rout & !rempty. rptr increments on the edge.
- Flag sampling: wfull and rempty are sampled before the edge, so at full a simultaneous win+rout performs only the read, and at empty it performs only the write. There is no write-to-read bypass.
- Count: next count = count + wen - ren. Simultaneous accepted read and write leaves count unchanged.
- Status flags (wfull, rempty, almost_full, almost_empty) are registered, computed from next count, and therefore exact in the cycle after the edge.
- Standard mode (FWFT=0):
  - On ren, rdata <= mem[raddr] and rvalid <= 1; otherwise rvalid <= 0 and rdata holds. Read latency is 1 clk.
- FWFT mode (FWFT=1):
  - rdata = mem[raddr] combinationally and rvalid = !rempty.
  - The first word appears 1 clk after the write that made the FIFO non-empty.
  - rout acts as an acknowledge/pop.
- Error flags:
  - win & wfull sets overflow; rout & rempty sets underflow. The rejected operation has no other effect.
  - flag_clr clears both flags. If a set and a clear occur in the same cycle, set wins.
- Thresholds are compared on the unsigned count, ASIZE+1 bits wide, with no truncation.

Decomposition:
- Shared package fifo_pkg holds:
  - the DEPTH derivation
  - a count/pointer width helper
  - default threshold localparams
  - the FWFT mode encoding constants (MODE_STD = 0, MODE_FWFT = 1)
- One sub-module, fifo_dpram: simple dual-port RAM, DSIZE x DEPTH, synchronous write on clk with write enable, asynchronous read.
- Pointer, count, flag and read-register logic stays in sync_fifo_thresh.

Test Plan:
- Reset then 16 writes of 0x00..0x0F (DSIZE=8, ASIZE=4) -> count steps 1..16; almost_full rises when count reaches 12; wfull=1 after the 16th write; a 17th win sets overflow=1 while count stays 16.
- From full, 16 reads (FWFT=0) -> rdata 0x00..0x0F, each with rvalid one cycle after rout; rempty=1 at the end; an extra rout sets underflow=1 and rdata holds 0x0F.
- Wrap-around: write 10, read 10, then write 16 distinct values and read 16 -> data in order, pointers cross the address wrap, and wfull/rempty are correct throughout.
- Simultaneous win+rout at count 0, 5 and 16 -> count becomes 1, stays 5, and becomes 15 respectively; at empty no rvalid; at full the write is dropped and overflow is set.
- FWFT=1: a single write of 0xA5 -> next cycle rempty=0, rvalid=1, rdata=0xA5 with no rout; rout pops it and rempty=1 next cycle.
- Write 7 words, then assert rst in the same cycle as win and flag_clr -> next cycle count=0, rempty=1, flags=0, and the write is dropped; a subsequent write/read returns the new data.

Source files
------------

// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared sizing helpers, default thresholds and read-mode encodings for the FIFO family
package fifo_pkg;

  localparam int DSIZE_DEF     = 8;
  localparam int ASIZE_DEF     = 4;
  localparam int AFULL_TH_DEF  = 12;
  localparam int AEMPTY_TH_DEF = 2;

  localparam int MODE_STD  = 0;
  localparam int MODE_FWFT = 1;

  function automatic int depth_of(input int asize);
    return 1 << asize;
  endfunction

  // One extra bit so a full FIFO (DEPTH entries) is distinguishable from empty.
  function automatic int cnt_width(input int asize);
    return asize + 1;
  endfunction

endpackage

// File: rtl/sync_fifo_thresh_if.sv
// rtl/sync_fifo_thresh_if.sv - producer/consumer bus of the threshold FIFO
interface sync_fifo_thresh_if #(
  parameter int DSIZE = 8,
  parameter int ASIZE = 4
);
  logic [DSIZE-1:0] wdata;
  logic             win;
  logic             rout;
  logic             flag_clr;
  logic [DSIZE-1:0] rdata;
  logic             rvalid;
  logic             wfull;
  logic             rempty;
  logic             almost_full;
  logic             almost_empty;
  logic [ASIZE:0]   count;
  logic             overflow;
  logic             underflow;

  modport master (
    output wdata, win, rout, flag_clr,
    input  rdata, rvalid, wfull, rempty, almost_full, almost_empty, count, overflow, underflow
  );

  modport slave (
    input  wdata, win, rout, flag_clr,
    output rdata, rvalid, wfull, rempty, almost_full, almost_empty, count, overflow, underflow
  );
endinterface

// File: rtl/fifo_dpram.sv
// rtl/fifo_dpram.sv - simple dual-port RAM, synchronous write, asynchronous read
module fifo_dpram
  import fifo_pkg::*;
#(
  parameter int DSIZE = DSIZE_DEF,
  parameter int ASIZE = ASIZE_DEF
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [ASIZE-1:0] waddr_i,
  input  logic [DSIZE-1:0] wdata_i,
  input  logic [ASIZE-1:0] raddr_i,
  output logic [DSIZE-1:0] rdata_o
);
  localparam int DEPTH = depth_of(ASIZE);

  logic [DSIZE-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/sync_fifo_thresh.sv
// rtl/sync_fifo_thresh.sv - single-clock FIFO with occupancy count, almost flags,
// sticky overflow/underflow and selectable first-word-fall-through read
module sync_fifo_thresh
  import fifo_pkg::*;
#(
  parameter int DSIZE     = DSIZE_DEF,
  parameter int ASIZE     = ASIZE_DEF,
  parameter int AFULL_TH  = AFULL_TH_DEF,
  parameter int AEMPTY_TH = AEMPTY_TH_DEF,
  parameter int FWFT      = MODE_STD
) (
  input logic               clk,
  input logic               rst,
  sync_fifo_thresh_if.slave bus
);
  localparam int DEPTH = depth_of(ASIZE);
  localparam int CW    = cnt_width(ASIZE);

  logic [CW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d, count_q, count_d;
  logic             wfull_q, wfull_d, rempty_q, rempty_d;
  logic             afull_q, afull_d, aempty_q, aempty_d;
  logic             ovf_q, ovf_d, unf_q, unf_d;
  logic             wen, ren;
  logic [DSIZE-1:0] mem_rdata;

  // Flags sampled before the edge decide acceptance; no write-to-read bypass.
  assign wen = bus.win  & ~wfull_q;
  assign ren = bus.rout & ~rempty_q;

  always_comb begin
    wptr_d   = wptr_q + CW'(wen);
    rptr_d   = rptr_q + CW'(ren);
    count_d  = count_q + CW'(wen) - CW'(ren);
    wfull_d  = (count_d == CW'(DEPTH));
    rempty_d = (count_d == '0);
    afull_d  = (count_d >= CW'(AFULL_TH));
    aempty_d = (count_d <= CW'(AEMPTY_TH));
    ovf_d    = (bus.win  & wfull_q)  | (ovf_q & ~bus.flag_clr);
    unf_d    = (bus.rout & rempty_q) | (unf_q & ~bus.flag_clr);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      count_q  <= '0;
      wfull_q  <= 1'b0;
      rempty_q <= 1'b1;
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      count_q  <= count_d;
      wfull_q  <= wfull_d;
      rempty_q <= rempty_d;
      afull_q  <= afull_d;
      aempty_q <= aempty_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  fifo_dpram #(.DSIZE(DSIZE), .ASIZE(ASIZE)) u_ram (
    .clk     (clk),
    .we_i    (wen),
    .waddr_i (wptr_q[ASIZE-1:0]),
    .wdata_i (bus.wdata),
    .raddr_i (rptr_q[ASIZE-1:0]),
    .rdata_o (mem_rdata)
  );

  if (FWFT == MODE_FWFT) begin : g_fwft
    // Head word is exposed directly; zeroed while empty so reset shows rdata = 0.
    assign bus.rdata  = rempty_q ? '0 : mem_rdata;
    assign bus.rvalid = ~rempty_q;
  end else begin : g_std
    logic [DSIZE-1:0] rdata_q;
    logic             rvalid_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        rdata_q  <= '0;
        rvalid_q <= 1'b0;
      end else begin
        rvalid_q <= ren;
        if (ren) rdata_q <= mem_rdata;
      end
    end

    assign bus.rdata  = rdata_q;
    assign bus.rvalid = rvalid_q;
  end

  assign bus.wfull        = wfull_q;
  assign bus.rempty       = rempty_q;
  assign bus.almost_full  = afull_q;
  assign bus.almost_empty = aempty_q;
  assign bus.count        = count_q;
  assign bus.overflow     = ovf_q;
  assign bus.underflow    = unf_q;
endmodule

// File: tb/tb_sync_fifo_thresh.sv
// tb/tb_sync_fifo_thresh.sv - directed bench for sync_fifo_thresh in standard and FWFT modes
module tb_sync_fifo_thresh;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  sync_fifo_thresh_if #(.DSIZE(8), .ASIZE(4)) s ();
  sync_fifo_thresh_if #(.DSIZE(8), .ASIZE(4)) f ();

  sync_fifo_thresh #(.DSIZE(8), .ASIZE(4), .AFULL_TH(12), .AEMPTY_TH(2), .FWFT(0)) u_std (
    .clk (clk),
    .rst (rst),
    .bus (s)
  );

  sync_fifo_thresh #(.DSIZE(8), .ASIZE(4), .AFULL_TH(12), .AEMPTY_TH(2), .FWFT(1)) u_fwft (
    .clk (clk),
    .rst (rst),
    .bus (f)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    s.wdata = '0; s.win = 1'b0; s.rout = 1'b0; s.flag_clr = 1'b0;
    f.wdata = '0; f.win = 1'b0; f.rout = 1'b0; f.flag_clr = 1'b0;
    step();
    check("rst_count",  s.count, 0);
    check("rst_rempty", s.rempty, 1);
    check("rst_wfull",  s.wfull, 0);
    check("rst_aempty", s.almost_empty, 1);
    check("rst_afull",  s.almost_full, 0);
    check("rst_rdata",  s.rdata, 0);
    check("rst_rvalid", s.rvalid, 0);
    check("rst_ovf",    s.overflow, 0);
    check("rst_unf",    s.underflow, 0);
    check("rst_f_rempty", f.rempty, 1);
    check("rst_f_rvalid", f.rvalid, 0);
    rst = 1'b0;

    // fill 0x00..0x0F
    s.win = 1'b1;
    for (int i = 0; i < 16; i++) begin
      s.wdata = 8'(i);
      step();
      check("fill_count",  s.count, i + 1);
      check("fill_afull",  s.almost_full, (i + 1 >= 12) ? 1 : 0);
      check("fill_wfull",  s.wfull, (i + 1 == 16) ? 1 : 0);
      check("fill_aempty", s.almost_empty, (i + 1 <= 2) ? 1 : 0);
      check("fill_rempty", s.rempty, 0);
    end
    s.wdata = 8'hEE;
    step();
    check("ovf_set",   s.overflow, 1);
    check("ovf_count", s.count, 16);
    check("ovf_wfull", s.wfull, 1);
    s.win = 1'b0;

    // drain, one cycle read latency
    s.rout = 1'b1;
    for (int i = 0; i < 16; i++) begin
      step();
      check("drain_rvalid", s.rvalid, 1);
      check("drain_rdata",  s.rdata, i);
      check("drain_count",  s.count, 15 - i);
    end
    check("drain_rempty", s.rempty, 1);
    step();
    check("unf_set",    s.underflow, 1);
    check("unf_rdata",  s.rdata, 8'h0F);
    check("unf_rvalid", s.rvalid, 0);
    check("unf_count",  s.count, 0);

    // clear coincident with a fresh underflow: set wins
    s.flag_clr = 1'b1;
    step();
    check("clr_setwins_unf", s.underflow, 1);
    check("clr_ovf",         s.overflow, 0);
    s.rout = 1'b0;
    step();
    check("clr_unf", s.underflow, 0);
    s.flag_clr = 1'b0;

    // wrap-around: 10 in/out, then 16 in/out crossing the address wrap
    s.win = 1'b1;
    for (int i = 0; i < 10; i++) begin
      s.wdata = 8'(8'h20 + i);
      step();
    end
    s.win = 1'b0;
    check("wrap10_count", s.count, 10);
    s.rout = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      check("wrap10_rdata", s.rdata, 8'h20 + i);
    end
    s.rout = 1'b0;
    check("wrap10_rempty", s.rempty, 1);
    s.win = 1'b1;
    for (int i = 0; i < 16; i++) begin
      s.wdata = 8'(8'h40 + i);
      step();
      check("wrap16_wfull", s.wfull, (i == 15) ? 1 : 0);
    end
    s.win = 1'b0;
    s.rout = 1'b1;
    for (int i = 0; i < 16; i++) begin
      step();
      check("wrap16_rdata",  s.rdata, 8'h40 + i);
      check("wrap16_rempty", s.rempty, (i == 15) ? 1 : 0);
    end
    s.rout = 1'b0;

    // simultaneous read+write at empty, mid and full
    s.win = 1'b1; s.rout = 1'b1; s.wdata = 8'h55;
    step();
    check("sim0_count",  s.count, 1);
    check("sim0_rvalid", s.rvalid, 0);
    check("sim0_unf",    s.underflow, 1);
    s.win = 1'b0; s.rout = 1'b0; s.flag_clr = 1'b1;
    step();
    s.flag_clr = 1'b0;
    s.win = 1'b1;
    for (int i = 0; i < 4; i++) begin
      s.wdata = 8'(8'h56 + i);
      step();
    end
    check("sim5_pre", s.count, 5);
    s.rout = 1'b1; s.wdata = 8'h5A;
    step();
    check("sim5_count",  s.count, 5);
    check("sim5_rvalid", s.rvalid, 1);
    check("sim5_rdata",  s.rdata, 8'h55);
    s.rout = 1'b0;
    for (int i = 0; i < 11; i++) begin
      s.wdata = 8'(8'h5B + i);
      step();
    end
    check("sim16_wfull", s.wfull, 1);
    s.rout = 1'b1; s.wdata = 8'h77;
    step();
    check("sim16_count",  s.count, 15);
    check("sim16_ovf",    s.overflow, 1);
    check("sim16_rdata",  s.rdata, 8'h56);
    check("sim16_wfull",  s.wfull, 0);
    s.win = 1'b0;
    for (int i = 0; i < 15; i++) begin
      step();
      check("sim16_drain", s.rdata, 8'h57 + i);
    end
    s.rout = 1'b0;
    check("sim16_empty", s.rempty, 1);

    // reset beats a coincident write and flag_clr
    s.rout = 1'b1;
    step();
    s.rout = 1'b0;
    check("rst2_unf_pre", s.underflow, 1);
    s.win = 1'b1;
    for (int i = 0; i < 7; i++) begin
      s.wdata = 8'(8'h90 + i);
      step();
    end
    check("rst2_count_pre", s.count, 7);
    rst = 1'b1; s.flag_clr = 1'b1; s.wdata = 8'hDD;
    step();
    check("rst2_count",  s.count, 0);
    check("rst2_rempty", s.rempty, 1);
    check("rst2_wfull",  s.wfull, 0);
    check("rst2_aempty", s.almost_empty, 1);
    check("rst2_ovf",    s.overflow, 0);
    check("rst2_unf",    s.underflow, 0);
    check("rst2_rvalid", s.rvalid, 0);
    check("rst2_rdata",  s.rdata, 0);
    rst = 1'b0; s.flag_clr = 1'b0; s.wdata = 8'hC3;
    step();
    s.win = 1'b0;
    check("rst2_wr_count", s.count, 1);
    s.rout = 1'b1;
    step();
    s.rout = 1'b0;
    check("rst2_rd_rdata",  s.rdata, 8'hC3);
    check("rst2_rd_rvalid", s.rvalid, 1);
    check("rst2_rd_rempty", s.rempty, 1);

    // first-word-fall-through instance
    f.win = 1'b1; f.wdata = 8'hA5;
    step();
    f.win = 1'b0;
    check("fwft_rempty", f.rempty, 0);
    check("fwft_rvalid", f.rvalid, 1);
    check("fwft_rdata",  f.rdata, 8'hA5);
    check("fwft_count",  f.count, 1);
    step();
    check("fwft_hold_rdata",  f.rdata, 8'hA5);
    check("fwft_hold_rvalid", f.rvalid, 1);
    f.rout = 1'b1;
    step();
    f.rout = 1'b0;
    check("fwft_pop_rempty", f.rempty, 1);
    check("fwft_pop_rvalid", f.rvalid, 0);
    check("fwft_pop_count",  f.count, 0);
    f.win = 1'b1; f.wdata = 8'hB1;
    step();
    f.wdata = 8'hB2;
    step();
    f.win = 1'b0;
    check("fwft2_head",  f.rdata, 8'hB1);
    check("fwft2_count", f.count, 2);
    f.rout = 1'b1;
    step();
    check("fwft2_next",   f.rdata, 8'hB2);
    check("fwft2_rvalid", f.rvalid, 1);
    step();
    f.rout = 1'b0;
    check("fwft2_rempty", f.rempty, 1);
    check("fwft2_unf",    f.underflow, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
